uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_send transmitter among NUM_REQ byte-stream requesters, e.g. a message ROM streamer, a debug/status dumper and a DIP-switch echo.
- Grants are round-robin and per packet: a requester keeps the UART until it has sent the byte flagged req_last.
- Sequences uart_send: loads uart_payload, pulses uart_start, then waits for uart_done before fetching the next byte.
- Sits between the requesters and uart_send in top; replaces the ad-hoc done-clocked counter logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; must match the uart_send payload width.
- TIMEOUT_CYCLES, 65535, watchdog limit in CLK cycles (used only with UART_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  requester i has a byte on req_data slice i.
- req_data  in  NUM_REQ*DATA_W  requester i byte at [DATA_W*i +: DATA_W].
- req_last  in  NUM_REQ  byte from requester i is the last of its packet.
- req_ready  out  NUM_REQ  one-cycle accept strobe; the byte is consumed when valid&ready.
- grant  out  NUM_REQ  one-hot current owner; 0 when idle.
- active  out  1  high while any grant is held.
- uart_start  out  1  to uart_send .ready; one-cycle start pulse.
- uart_payload  out  DATA_W  to uart_send .payload; held stable from load until uart_done.
- uart_busy  in  1  from uart_send .busy.
- uart_done  in  1  from uart_send .done; one-cycle pulse per byte.
- timeout_err  out  1  sticky watchdog flag; tied 0 when the feature is compiled out.

Behaviour:
Reset values (rst sampled high at posedge):
- state=IDLE, grant=0, active=0, req_ready=0, uart_start=0, uart_payload=0, timeout_err=0.
- Priority pointer=0; any packet in flight is dropped.
- uart_send shares rst, so it is reset in the same cycle.

States:
- IDLE:
  - If any req_valid is high, pick the first set bit scanning from pointer upward with wrap (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
  - Register that bit into grant, set active=1, go LOAD.
  - No req_ready is issued in IDLE.
- LOAD:
  - req_ready[k] = (state==LOAD) & grant[k] & req_valid[k], combinational.
  - On accept: latch req_data[k] into uart_payload and req_last[k] into last_q, go START.
  - If the owner's req_valid is low, stay in LOAD holding grant (packet lock). Other requesters are never served mid-packet.
- START:
  - uart_start = (state==START) & ~uart_busy, combinational.
  - Go WAIT_DONE in the cycle uart_start is high.
  - While uart_busy=1, hold in START.
- WAIT_DONE:
  - On uart_done with last_q=1: clear grant and active, set pointer = owner+1 mod NUM_REQ, go IDLE.
  - On uart_done with last_q=0: go LOAD.
  - uart_done seen in any other state is ignored.

Timing:
- Latency: req_valid rises in IDLE at cycle 0 -> grant at cycle 1 -> req_ready at cycle 1 -> uart_start at cycle 2 if uart_busy=0.
- Next byte of the same packet: req_ready the cycle after uart_done; start one cycle later.

Fairness:
- Pointer advances only on packet completion.
- Requesters asserting valid simultaneously are served in round-robin order. A single requester may repeatedly win only when no other valid is pending at its arbitration.

Edge cases:
- req_valid for a non-owner is ignored; that requester keeps req_valid asserted (no drop) until granted.
- NUM_REQ==1: the pointer is fixed at 0.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to START and counts each cycle in START or WAIT_DONE.
  - If it reaches TIMEOUT_CYCLES before uart_done: set timeout_err (sticky until rst), release grant, advance pointer past the owner, go IDLE.
  - The rest of the aborted packet is delivered only if the requester re-arbitrates.
- Undefined: no counter; the arbiter waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset mid-packet: rst in WAIT_DONE -> next cycle grant=0, uart_start=0, uart_payload=0, state IDLE; afterwards requester 1 alone wins first (pointer=0 scan).
- Single requester: req0 sends 3 bytes 0x48,0x69,0x21 (last on 0x21) with done model at 10 cycles -> exactly 3 uart_start pulses, payloads 0x48,0x69,0x21 in order; active drops the cycle after the third done.
- Contention: req0 and req2 both valid from reset, 2-byte packets each -> req0 bytes fully sent, then req2; the next simultaneous request from req0 and req2 grants req2 first... checked: the pointer is 3 after req2, so req0 wins; assert this ordering.
- Packet lock: req1 drops valid for 20 cycles after byte 1 of 2 while req3 is valid -> grant stays on req1, no req_ready[3], resumes when req1 revalidates.
- Busy hold: uart_busy held high 5 cycles on entry to START -> uart_start fires the first cycle busy=0, exactly once.
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=100): uart_done never pulses -> timeout_err=1 after 100 cycles, grant released, next requester granted; without the macro the arbiter stays in WAIT_DONE and timeout_err=0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_send transmitter among NUM_REQ byte streams.
// Optional watchdog: define UART_ARB_TIMEOUT_EN to abort a byte whose uart_done never arrives.
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      CLK,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      active,
    output logic                      uart_start,
    output logic [DATA_W-1:0]         uart_payload,
    input  logic                      uart_busy,
    input  logic                      uart_done,
    output logic                      timeout_err
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic               active_q, active_d;
    logic               last_q, last_d;
    logic [DATA_W-1:0]  payload_q, payload_d;

    logic [PTR_W-1:0]   pick_idx_s;
    logic               pick_found_s;
    logic [PTR_W-1:0]   owner_next_s;
    logic               wd_expire_s;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= unsigned'(NUM_REQ)) begin
            sum = sum - unsigned'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin scan starting at the priority pointer, wrapping past NUM_REQ-1.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pick_found_s && req_valid[wrap_idx(ptr_q, i)]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = wrap_idx(ptr_q, i);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    assign owner_next_s = (owner_q == LAST_IDX) ? '0 : owner_q + PTR_W'(1);

    // Next-state and handshake logic; a watchdog expiry overrides the normal sequence.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        active_d   = active_q;
        last_d     = last_q;
        payload_d  = payload_q;
        req_ready  = '0;
        uart_start = 1'b0;
        if (wd_expire_s) begin
            grant_d  = '0;
            active_d = 1'b0;
            ptr_d    = owner_next_s;
            state_d  = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found_s) begin
                        grant_d  = NUM_REQ'(1'b1) << pick_idx_s;
                        owner_d  = pick_idx_s;
                        active_d = 1'b1;
                        state_d  = LOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                LOAD: begin
                    // Packet lock: only the owner is offered ready, even while it stalls.
                    req_ready = grant_q & req_valid;
                    if (req_valid[owner_q]) begin
                        payload_d = req_data[owner_q*DATA_W +: DATA_W];
                        last_d    = req_last[owner_q];
                        state_d   = START;
                    end else begin
                        state_d   = LOAD;
                    end
                end
                START: begin
                    uart_start = ~uart_busy;
                    if (!uart_busy) begin
                        state_d = WAIT_DONE;
                    end else begin
                        state_d = START;
                    end
                end
                WAIT_DONE: begin
                    if (uart_done && last_q) begin
                        grant_d  = '0;
                        active_d = 1'b0;
                        ptr_d    = owner_next_s;
                        state_d  = IDLE;
                    end else if (uart_done) begin
                        state_d  = LOAD;
                    end else begin
                        state_d  = WAIT_DONE;
                    end
                end
                default: begin
                    grant_d  = '0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // Arbiter state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            active_q  <= 1'b0;
            last_q    <= 1'b0;
            payload_q <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            active_q  <= active_d;
            last_q    <= last_d;
            payload_q <= payload_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] wd_cnt_q, wd_cnt_d;
    logic        terr_q, terr_d;

    // Counter is held at zero outside START/WAIT_DONE, so it restarts on every START entry.
    always_comb begin
        wd_cnt_d    = 16'd0;
        wd_expire_s = 1'b0;
        terr_d      = terr_q;
        if (state_q == START || state_q == WAIT_DONE) begin
            wd_cnt_d    = wd_cnt_q + 16'd1;
            wd_expire_s = (wd_cnt_q == WD_LIMIT) && !((state_q == WAIT_DONE) && uart_done);
        end else begin
            wd_cnt_d    = 16'd0;
        end
        if (wd_expire_s) begin
            terr_d = 1'b1;
        end else begin
            terr_d = terr_q;
        end
    end

    // Watchdog counter and sticky error flag.
    always_ff @(posedge CLK) begin
        if (rst) begin
            wd_cnt_q <= 16'd0;
            terr_q   <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            terr_q   <= terr_d;
        end
    end

    assign timeout_err = terr_q;
`else
    assign wd_expire_s = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign grant        = grant_q;
    assign active       = active_q;
    assign uart_payload = payload_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed plus randomized bench for uart_tx_arbiter with a uart_send stand-in and a
// packet-level round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int TO = 100;

    logic         CLK = 1'b0;
    logic         rst;
    logic [N-1:0] req_valid, req_last, req_ready, grant;
    logic [N*8-1:0] req_data;
    logic         active, uart_start, uart_busy, uart_done, timeout_err;
    logic [7:0]   uart_payload;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .active(active),
        .uart_start(uart_start), .uart_payload(uart_payload), .uart_busy(uart_busy),
        .uart_done(uart_done), .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    logic [8:0]  rq [N][$];
    logic [10:0] exp_q[$], obs_q[$];
    int gap[N];
    int gap_mode, done_lat, u_cnt, m_ptr;
    bit suppress, busy_force, m_busy, prev_active;
    int n_vec, n_err, n_start, stray_ready, cyc, s_idx, last_done_idx, fall_idx;
    logic [N-1:0] s_grant, s_ready, s_hs;
    logic [7:0]   s_payload;
    logic         s_start, s_active, s_terr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] oh_idx(input logic [N-1:0] g);
        case (g)
            4'b0001: return 3'd0;
            4'b0010: return 3'd1;
            4'b0100: return 3'd2;
            4'b1000: return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    function automatic bit all_empty();
        for (int i = 0; i < N; i++) if (rq[i].size() > 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [2:0] obs_id(input int i);
        if (i < obs_q.size()) return obs_q[i][10:8];
        return 3'd7;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0 && gap[i] == 0) begin
                req_valid[i]      = 1'b1;
                req_data[8*i +: 8] = rq[i][0][7:0];
                req_last[i]       = rq[i][0][8];
            end else begin
                req_valid[i]      = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]       = 1'b0;
            end
        end
        uart_busy = m_busy | busy_force;
    endtask

    // One clock: sample on the falling edge, then update uart model and requesters after the rise.
    task automatic tick();
        logic [8:0] b;
        @(negedge CLK);
        s_idx = cyc;
        s_grant = grant; s_ready = req_ready; s_start = uart_start;
        s_payload = uart_payload; s_active = active; s_terr = timeout_err;
        s_hs = req_valid & req_ready;
        if (s_start) begin
            obs_q.push_back({oh_idx(s_grant), s_payload});
            n_start++;
        end
        if ((s_ready & ~s_grant) != '0) stray_ready++;
        if (uart_done) last_done_idx = s_idx;
        if (prev_active && !s_active) fall_idx = s_idx;
        prev_active = s_active;
        @(posedge CLK);
        #1;
        cyc++;
        if (uart_done) uart_done = 1'b0;
        if (s_start) begin
            u_cnt = done_lat; m_busy = 1'b1;
        end else if (u_cnt > 0) begin
            u_cnt--;
            if (u_cnt == 0) begin
                m_busy = 1'b0;
                if (!suppress) uart_done = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (s_hs[i] && rq[i].size() > 0) begin
                b = rq[i].pop_front();
                if (!b[8] && gap_mode == 1) gap[i] = $urandom_range(0, 5);
                else if (!b[8] && gap_mode == 2) gap[i] = 20;
            end else if (gap[i] > 0) begin
                gap[i]--;
            end
        end
        drive();
    endtask

    task automatic push_pkt(input int r, input int len);
        for (int j = 0; j < len; j++) rq[r].push_back({(j == len - 1), 8'($urandom)});
    endtask

    // Reference: whole packets in round-robin order, pointer moves past each finished owner.
    task automatic model_build();
        logic [8:0] mq [N][$];
        logic [8:0] b;
        int k;
        bit any;
        for (int i = 0; i < N; i++) mq[i] = rq[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            k = 0;
            for (int j = 0; j < N; j++) begin
                if (!any && mq[(m_ptr + j) % N].size() > 0) begin
                    k = (m_ptr + j) % N;
                    any = 1'b1;
                end
            end
            if (any) begin
                do begin
                    b = mq[k].pop_front();
                    exp_q.push_back({3'(k), b[7:0]});
                end while (!b[8] && mq[k].size() > 0);
                m_ptr = (k + 1) % N;
            end
        end
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!(all_empty() && !s_active && u_cnt == 0 && !uart_done) && k < budget);
        check({tag, "_within_budget"}, 32'(k < budget), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_byte_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check({tag, "_byte"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin rq[i].delete(); gap[i] = 0; end
        busy_force = 1'b0; suppress = 1'b0;
        drive();
        tick();
        rst = 1'b0;
        u_cnt = 0; m_busy = 1'b0; uart_done = 1'b0;
        drive();
        m_ptr = 0;
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int base, k;
        n_vec = 0; n_err = 0; n_start = 0; stray_ready = 0; cyc = 0;
        gap_mode = 0; done_lat = 10; u_cnt = 0; m_ptr = 0;
        suppress = 1'b0; busy_force = 1'b0; m_busy = 1'b0; prev_active = 1'b0;
        last_done_idx = 0; fall_idx = 0;
        for (int i = 0; i < N; i++) gap[i] = 0;
        rst = 1'b1; uart_done = 1'b0;
        drive();
        tick(); tick();
        check("rst_grant", s_grant, 0);
        check("rst_active", s_active, 0);
        check("rst_ready", s_ready, 0);
        check("rst_start", s_start, 0);
        check("rst_payload", s_payload, 0);
        check("rst_timeout_err", s_terr, 0);
        rst = 1'b0;
        obs_q.delete();

        // Single requester, three-byte packet, checking first-byte latency.
        rq[0].push_back({1'b0, 8'h48}); rq[0].push_back({1'b0, 8'h69}); rq[0].push_back({1'b1, 8'h21});
        model_build();
        drive();
        base = n_start;
        tick();
        check("lat_idle_grant", s_grant, 0);
        check("lat_idle_ready", s_ready, 0);
        tick();
        check("lat_grant", s_grant, 4'b0001);
        check("lat_ready", s_ready, 4'b0001);
        tick();
        check("lat_start", s_start, 1);
        run_until_idle(300, "single");
        check("single_starts", n_start - base, 3);
        check("single_active_fall", fall_idx - last_done_idx, 1);
        compare_stream("single");

        // Contention between req0 and req2, two 2-byte packets each.
        do_reset();
        push_pkt(0, 2); push_pkt(2, 2); push_pkt(0, 2); push_pkt(2, 2);
        model_build();
        drive();
        run_until_idle(500, "contend");
        for (int p = 0; p < 4; p++)
            check("contend_owner", obs_id(2 * p), (p % 2 == 0) ? 0 : 2);
        compare_stream("contend");

        // Reset while a byte is in flight.
        push_pkt(2, 2);
        drive();
        k = 0;
        do begin tick(); k++; end while (!s_start && k < 10);
        check("midrst_started", s_start, 1);
        repeat (3) tick();
        do_reset();
        tick();
        check("midrst_grant", s_grant, 0);
        check("midrst_start", s_start, 0);
        check("midrst_payload", s_payload, 0);
        check("midrst_active", s_active, 0);

        // Packet lock: req1 stalls mid-packet while req3 waits.
        push_pkt(1, 2); push_pkt(3, 1);
        model_build();
        gap_mode = 2;
        drive();
        k = 0;
        do begin tick(); k++; end while (!s_hs[1] && k < 20);
        check("lock_first_accept", s_hs[1], 1);
        check("lock_first_owner", s_grant, 4'b0010);
        for (int c = 0; c < 20; c++) begin
            tick();
            check("lock_grant_held", s_grant, 4'b0010);
            check("lock_no_ready3", s_ready[3], 0);
        end
        gap_mode = 0;
        run_until_idle(300, "lock");
        compare_stream("lock");

        // Busy hold on entry to START.
        push_pkt(0, 1);
        model_build();
        busy_force = 1'b1;
        drive();
        k = 0;
        do begin tick(); k++; end while (!s_hs[0] && k < 10);
        base = n_start;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("busy_no_start", s_start, 0);
        end
        busy_force = 1'b0;
        drive();
        tick();
        check("busy_start", s_start, 1);
        run_until_idle(100, "busy");
        check("busy_start_count", n_start - base, 1);
        compare_stream("busy");

        // Randomized rounds against the packet-level model.
        gap_mode = 1;
        for (int r = 0; r < 5; r++) begin
            done_lat = $urandom_range(1, 12);
            for (int i = 0; i < N; i++)
                for (int p = 0; p < int'($urandom_range(0, 2)); p++) push_pkt(i, $urandom_range(1, 4));
            if (all_empty()) push_pkt($urandom_range(0, N - 1), 2);
            model_build();
            drive();
            run_until_idle(3000, "random");
            compare_stream("random");
        end
        gap_mode = 0;
        done_lat = 10;
        check("no_stray_ready", stray_ready, 0);

        // uart_done never arrives.
        do_reset();
        suppress = 1'b1;
        push_pkt(1, 2); push_pkt(2, 1);
        drive();
        k = 0;
        do begin tick(); k++; end while (!s_start && k < 10);
        check("wd_first_start", s_start, 1);
        base = s_idx;
`ifdef UART_ARB_TIMEOUT_EN
        k = 0;
        do begin tick(); k++; end while (!s_terr && k < 300);
        check("wd_cycles", s_idx - base, TO);
        k = 0;
        do begin tick(); k++; end while (s_grant != 4'b0100 && k < 10);
        check("wd_next_owner", s_grant, 4'b0100);
        check("wd_sticky", s_terr, 1);
`else
        base = n_start;
        repeat (150) tick();
        check("nowd_grant", s_grant, 4'b0010);
        check("nowd_active", s_active, 1);
        check("nowd_timeout_err", s_terr, 0);
        check("nowd_no_restart", n_start - base, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
